// File: rtl/game_state_controller_if.sv
// -----------------------------------------------------------------------------
// game_state_controller_if
// Purpose : Bundles the command and status signals exchanged between the game
//           state controller and the rest of the game (input decoder, meteor
//           field, renderer).
// Signals : start_game             one-cycle start/restart pulse
//           move_left/right/up/down level-held direction requests
//           collision               level, player overlaps a meteor
//           state[1:0]              IDLE=0, COUNTDOWN=1, PLAYING=2, GAME_OVER=3
//           playing, game_over      decodes of state
//           frame_tick              one-cycle pulse per frame
//           clear_field             one-cycle pulse: meteor field must clear
//           player_x/y[3:0]         player position, y=0 is the top row
//           score[15:0]             survived frame ticks
// Modports: master - the game side, drives commands and reads status
//           slave  - the controller, reads commands and drives status
// -----------------------------------------------------------------------------
interface game_state_controller_if;

  logic        start_game;
  logic        move_left;
  logic        move_right;
  logic        move_up;
  logic        move_down;
  logic        collision;

  logic [1:0]  state;
  logic        playing;
  logic        game_over;
  logic        frame_tick;
  logic        clear_field;
  logic [3:0]  player_x;
  logic [3:0]  player_y;
  logic [15:0] score;

  modport master (
    output start_game, move_left, move_right, move_up, move_down, collision,
    input  state, playing, game_over, frame_tick, clear_field,
           player_x, player_y, score
  );

  modport slave (
    input  start_game, move_left, move_right, move_up, move_down, collision,
    output state, playing, game_over, frame_tick, clear_field,
           player_x, player_y, score
  );

endinterface : game_state_controller_if

// File: rtl/game_state_controller.sv
// -----------------------------------------------------------------------------
// game_state_controller
// Purpose : Top-level game sequencer for a dodge-the-meteors game. Generates
//           the frame tick, runs the IDLE -> COUNTDOWN -> PLAYING -> GAME_OVER
//           state machine, moves the player on the grid once per frame and
//           counts survived frames as the score.
// Ports   : clk    - system clock, rising edge
//           reset  - asynchronous, active-low reset
//           bus    - game_state_controller_if.slave (commands in, status out)
// Params  : TICK_DIV    clk cycles per frame tick (2..2^20)
//           COUNT_TICKS frame ticks spent in COUNTDOWN (1..255)
//           GRID_MAX_X/Y maximum column/row (1..15)
//           START_X/Y   spawn position
// -----------------------------------------------------------------------------
module game_state_controller #(
  parameter int TICK_DIV    = 833333,
  parameter int COUNT_TICKS = 180,
  parameter int GRID_MAX_X  = 15,
  parameter int GRID_MAX_Y  = 15,
  parameter int START_X     = 7,
  parameter int START_Y     = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  game_state_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_PLAYING   = 2'd2,
    S_GAME_OVER = 2'd3
  } state_e;

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]        CD_LAST   = 8'(COUNT_TICKS - 1);
  localparam logic [3:0]        MAX_X     = 4'(GRID_MAX_X);
  localparam logic [3:0]        MAX_Y     = 4'(GRID_MAX_Y);
  localparam logic [3:0]        SPAWN_X   = 4'(START_X);
  localparam logic [3:0]        SPAWN_Y   = 4'(START_Y);

  state_e              state_q,       state_d;
  logic [TICK_W-1:0]   tick_cnt_q,    tick_cnt_d;
  logic                frame_tick_q,  frame_tick_d;
  logic [7:0]          cd_cnt_q,      cd_cnt_d;
  logic                clear_field_q, clear_field_d;
  logic [3:0]          x_q,           x_d;
  logic [3:0]          y_q,           y_d;
  logic [15:0]         score_q,       score_d;

  logic                go_left, go_right, go_up, go_down;

  // Opposing requests cancel; a request at the edge of the grid holds.
  assign go_left  = bus.move_left  && !bus.move_right && (x_q != 4'd0);
  assign go_right = bus.move_right && !bus.move_left  && (x_q <  MAX_X);
  assign go_up    = bus.move_up    && !bus.move_down  && (y_q != 4'd0);
  assign go_down  = bus.move_down  && !bus.move_up    && (y_q <  MAX_Y);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_d       = state_q;
    cd_cnt_d      = cd_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    score_d       = score_q;
    clear_field_d = 1'b0;

    // Free-running frame divider. frame_tick is registered, so it is computed
    // from the counter's next value to line up with the TICK_DIV-1 cycle.
    tick_cnt_d   = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    frame_tick_d = (tick_cnt_d == TICK_LAST);

    unique case (state_q)
      S_IDLE, S_GAME_OVER: begin
        // GAME_OVER freezes position and score; only a (re)start leaves it.
        if (bus.start_game) begin
          state_d       = S_COUNTDOWN;
          cd_cnt_d      = 8'd0;
          x_d           = SPAWN_X;
          y_d           = SPAWN_Y;
          score_d       = 16'd0;
          clear_field_d = 1'b1;
        end
      end

      S_COUNTDOWN: begin
        if (frame_tick_q) begin
          cd_cnt_d = cd_cnt_q + 8'd1;
          if (cd_cnt_q == CD_LAST) state_d = S_PLAYING;
        end
      end

      S_PLAYING: begin
        // Collision wins over a coincident tick: the frame is not scored.
        if (bus.collision) begin
          state_d = S_GAME_OVER;
        end else if (frame_tick_q) begin
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          if (go_left)  x_d = x_q - 4'd1;
          if (go_right) x_d = x_q + 4'd1;
          if (go_up)    y_d = y_q - 4'd1;
          if (go_down)  y_d = y_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      frame_tick_q  <= 1'b0;
      cd_cnt_q      <= 8'd0;
      clear_field_q <= 1'b0;
      x_q           <= SPAWN_X;
      y_q           <= SPAWN_Y;
      score_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      frame_tick_q  <= frame_tick_d;
      cd_cnt_q      <= cd_cnt_d;
      clear_field_q <= clear_field_d;
      x_q           <= x_d;
      y_q           <= y_d;
      score_q       <= score_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.playing     = (state_q == S_PLAYING);
  assign bus.game_over   = (state_q == S_GAME_OVER);
  assign bus.frame_tick  = frame_tick_q;
  assign bus.clear_field = clear_field_q;
  assign bus.player_x    = x_q;
  assign bus.player_y    = y_q;
  assign bus.score       = score_q;

endmodule : game_state_controller

// File: tb/tb_game_state_controller.sv
// -----------------------------------------------------------------------------
// tb_game_state_controller
// Purpose : Directed self-checking bench for game_state_controller with a
//           short frame (TICK_DIV=4) and countdown (COUNT_TICKS=2). Inputs are
//           driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_game_state_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  game_state_controller_if gif ();

  game_state_controller #(
    .TICK_DIV   (4),
    .COUNT_TICKS(2),
    .GRID_MAX_X (15),
    .GRID_MAX_Y (15),
    .START_X    (7),
    .START_Y    (14)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: through the rising edge to the next falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance to the falling edge inside the next frame_tick cycle (bounded).
  task automatic wait_tick();
    int n;
    n = 0;
    while (gif.frame_tick !== 1'b1 && n < 16) begin
      cycle();
      n++;
    end
    check("tick_seen", gif.frame_tick, 1);
  endtask

  task automatic check_status(input string tag, input logic [1:0] st,
                              input logic [3:0] x, input logic [3:0] y,
                              input logic [15:0] sc);
    check({tag, "_state"}, gif.state, st);
    check({tag, "_x"}, gif.player_x, x);
    check({tag, "_y"}, gif.player_y, y);
    check({tag, "_score"}, gif.score, sc);
  endtask

  // From a non-tick cycle: start pulse, then two frame ticks of countdown.
  task automatic start_and_countdown(input string tag);
    gif.start_game = 1'b1;
    cycle();
    gif.start_game = 1'b0;
    check_status({tag, "_start"}, 2'd1, 4'd7, 4'd14, 16'd0);
    check({tag, "_clear_hi"}, gif.clear_field, 1);
    cycle();
    check({tag, "_clear_lo"}, gif.clear_field, 0);
    wait_tick();
    cycle();
    check({tag, "_cd_mid"}, gif.state, 1);
    wait_tick();
    cycle();
    check_status({tag, "_play"}, 2'd2, 4'd7, 4'd14, 16'd0);
    check({tag, "_playing"}, gif.playing, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset          = 1'b0;
    gif.start_game = 1'b0;
    gif.move_left  = 1'b0;
    gif.move_right = 1'b0;
    gif.move_up    = 1'b0;
    gif.move_down  = 1'b0;
    gif.collision  = 1'b0;

    // Reset values while reset is held low.
    #12;
    check_status("rst", 2'd0, 4'd7, 4'd14, 16'd0);
    check("rst_tick", gif.frame_tick, 0);
    check("rst_clear", gif.clear_field, 0);
    check("rst_playing", gif.playing, 0);
    check("rst_gameover", gif.game_over, 0);

    // First tick lands in the fourth cycle after release, for one cycle only.
    @(negedge clk);
    reset = 1'b1;
    cycle();
    cycle();
    check("tick_early", gif.frame_tick, 0);
    cycle();
    check("tick_first", gif.frame_tick, 1);
    cycle();
    check("tick_one_cycle", gif.frame_tick, 0);
    check("idle_state", gif.state, 0);

    // Start, with an ignored start pulse in the middle of the countdown.
    gif.start_game = 1'b1;
    cycle();
    gif.start_game = 1'b0;
    check("cd_state", gif.state, 1);
    check("cd_clear_hi", gif.clear_field, 1);
    gif.start_game = 1'b1;
    gif.move_left  = 1'b1;
    gif.collision  = 1'b1;
    cycle();
    gif.start_game = 1'b0;
    gif.collision  = 1'b0;
    check("cd_start_ignored_clear", gif.clear_field, 0);
    check_status("cd_ignore", 2'd1, 4'd7, 4'd14, 16'd0);
    gif.move_left = 1'b0;
    wait_tick();
    cycle();
    check("cd_after_tick1", gif.state, 1);
    wait_tick();
    cycle();
    check_status("play", 2'd2, 4'd7, 4'd14, 16'd0);

    // Hold left for 10 ticks: 6,5,...,0 then pinned at the left edge.
    gif.move_left = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      wait_tick();
      cycle();
      check("left_x", gif.player_x, (i <= 7) ? 7 - i : 0);
      check("left_score", gif.score, i);
    end
    gif.move_left = 1'b0;
    check("left_y", gif.player_y, 14);

    // Collision in a tick cycle with up held: no move, no score.
    wait_tick();
    gif.collision = 1'b1;
    gif.move_up   = 1'b1;
    cycle();
    gif.collision = 1'b0;
    gif.move_up   = 1'b0;
    check_status("coll", 2'd3, 4'd0, 4'd14, 16'd10);
    check("coll_gameover", gif.game_over, 1);
    check("coll_playing", gif.playing, 0);

    // GAME_OVER freezes everything across further ticks.
    gif.move_right = 1'b1;
    wait_tick();
    cycle();
    gif.move_right = 1'b0;
    check_status("frozen", 2'd3, 4'd0, 4'd14, 16'd10);

    // Restart from GAME_OVER.
    start_and_countdown("restart");

    // Left+right cancel, down reaches the bottom row and holds.
    gif.move_left  = 1'b1;
    gif.move_right = 1'b1;
    gif.move_down  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_tick();
      cycle();
      check("lrd_x", gif.player_x, 7);
      check("lrd_y", gif.player_y, 15);
      check("lrd_score", gif.score, i);
    end
    gif.move_left = 1'b0;
    gif.move_down = 1'b0;

    // Diagonal: right and up in the same tick.
    gif.move_up = 1'b1;
    wait_tick();
    cycle();
    gif.move_right = 1'b0;
    gif.move_up    = 1'b0;
    check_status("diag", 2'd2, 4'd8, 4'd14, 16'd4);

    // start_game ignored while PLAYING.
    gif.start_game = 1'b1;
    cycle();
    gif.start_game = 1'b0;
    check_status("play_start", 2'd2, 4'd8, 4'd14, 16'd4);
    check("play_start_clear", gif.clear_field, 0);

    // Score saturation from 16'hFFFE.
    force dut.score_q = 16'hFFFE;
    #1;
    release dut.score_q;
    cycle();
    check("sat_preset", gif.score, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      cycle();
      check("sat_score", gif.score, 16'hFFFF);
    end

    // Asynchronous reset mid-PLAYING, observed before the next rising edge.
    gif.move_left = 1'b1;
    wait_tick();
    cycle();
    gif.move_left = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_status("async_rst", 2'd0, 4'd7, 4'd14, 16'd0);
    check("async_rst_playing", gif.playing, 0);
    check("async_rst_tick", gif.frame_tick, 0);
    @(negedge clk);
    reset = 1'b1;
    cycle();
    check("post_rst_state", gif.state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_game_state_controller
